gate_truth_table_sequencer: RTL and testbench
=============================================

// Module: gate_truth_table_sequencer
// PURPOSE
//   Automatic truth-table checker for the combinational logic-gate blocks (nand/and/or/xor...).
//   Drives every input vector of a gate under test in ascending order and waits SETTLE cycles.
//   Samples the gate output, compares it with a parameterised expected table and counts mismatches.
//   Reports pass/fail, so the gate library self-checks in hardware instead of by eye in a $monitor dump.
// PARAMETERS
//   N_IN    2        number of gate inputs (1..4); vectors 0 .. 2**N_IN-1
//   SETTLE  1        wait cycles between driving a vector and sampling (0..15)
//   EXPECT  4'b0111  expected output table, width 2**N_IN; bit v = gate output for input vector v (default = NAND)
// PORTS
//   clk         in   1         single clock, rising edge
//   rst_n       in   1         synchronous, active-low reset
//   start       in   1         run request; accepted only in IDLE
//   abort       in   1         cancel a run in progress
//   gate_out    in   1         output of gate under test (combinational from gate_in)
//   gate_in     out  N_IN      input vector to gate under test; gate_in[N_IN-1] = a (MSB)
//   busy        out  1         run in progress (SETTLE/SAMPLE states)
//   done        out  1         one-cycle pulse at end of a complete run
//   pass        out  1         1 = last completed run had zero mismatches; held until next start
//   err_count   out  N_IN+1    mismatches in current/last run (max 2**N_IN, no saturation needed)
//   fail_valid  out  1         at least one mismatch recorded in current/last run
//   fail_vec    out  N_IN      first failing vector; valid when fail_valid=1
// BEHAVIOUR
//   - Clock and reset: one clock; reset is synchronous and active-low.
//   - All outputs registered. Reset (rst_n=0 at edge): state=IDLE, gate_in=0, busy=0, done=0, pass=0,
//     err_count=0, fail_valid=0, fail_vec=0. Reset mid-run discards the run; no done pulse.
//   - States: IDLE, SETTLE, SAMPLE, DONE. Internal vector index idx (N_IN bits), wait counter wcnt.
//   - IDLE: start=1 at edge -> idx=0, gate_in=0, err_count=0, fail_valid=0, fail_vec=0, pass=0, busy=1.
//     Next state is SETTLE with wcnt=SETTLE-1, or SAMPLE directly if SETTLE=0.
//   - SETTLE: gate_in held. Go to SAMPLE when wcnt==0, else decrement wcnt.
//   - SAMPLE: compare gate_out with EXPECT[idx].
//     On mismatch: err_count+=1; if fail_valid==0 then fail_vec=idx and fail_valid=1.
//     idx==2**N_IN-1 -> DONE, busy=0, done=1, pass=(final err_count==0), counting this cycle's mismatch.
//     Otherwise: idx+=1, gate_in=idx+1, then SETTLE (wcnt=SETTLE-1) or SAMPLE if SETTLE=0.
//   - Each vector occupies SETTLE+1 cycles. done is high in the cycle beginning 2**N_IN*(SETTLE+1) edges after the start edge.
//   - DONE: lasts exactly one cycle, then IDLE; done returns to 0. gate_in keeps the last vector until the next start.
//     A start seen in DONE is ignored; start held high is accepted in the following IDLE cycle.
//   - start is ignored while busy (no restart, no effect on counts).
//   - abort=1 in SETTLE/SAMPLE at edge -> IDLE, busy=0, gate_in=0, pass=0; no done pulse.
//     err_count, fail_valid and fail_vec keep their partial values. abort in IDLE/DONE has no effect.
//   - abort and rst_n both active: reset wins. abort and start both high in IDLE: start wins.
//   - idx never wraps: the run ends at the last vector.
// TESTING  (defaults N_IN=2, SETTLE=1, EXPECT=4'b0111 unless noted)
//   1. nand model on gate_out, 1-cycle start pulse
//      -> gate_in 00,01,10,11, each held 2 cycles; done high 8 edges after start for exactly 1 cycle.
//      -> pass=1, err_count=0, fail_valid=0; busy low in the done cycle.
//   2. and model instead of nand -> all 4 vectors mismatch: err_count=4, fail_valid=1, fail_vec=2'b00, pass=0.
//   3. gate_out stuck at 1 -> err_count=1, fail_vec=2'b11, pass=0.
//      Rerun with the nand model -> counters cleared at start; pass=1.
//   4. start held high continuously -> no effect mid-run; a second run starts in the IDLE cycle after done.
//      Exactly one done pulse per run; SETTLE=0 variant gives done 4 edges after start.
//   5. abort while gate_in=2'b10 -> next cycle IDLE, busy=0, gate_in=0, pass=0; no done pulse.
//      err_count holds its partial value.
//   6. rst_n=0 for one edge during SAMPLE of vector 01 -> all outputs at reset values.
//      No done pulse; a new start then runs normally.

Source files
------------

// File: rtl/gate_truth_table_sequencer.sv
// Hardware truth-table checker: walks every input vector of a gate under test,
// samples its output after a settle delay and records mismatches against EXPECT.
module gate_truth_table_sequencer #(
   parameter int                 N_IN   = 2,
   parameter int                 SETTLE = 1,
   parameter logic [2**N_IN-1:0] EXPECT = 4'b0111
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic            gate_out_i,
   output logic [N_IN-1:0] gate_in_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            pass_o,
   output logic [N_IN:0]   err_count_o,
   output logic            fail_valid_o,
   output logic [N_IN-1:0] fail_vec_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Wait counter reload; unused when SETTLE=0 because SETTLE is skipped.
   localparam logic [3:0] WLOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
   localparam logic [1:0] S_AFTER_VEC = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

   logic [1:0]      state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic [N_IN-1:0] gate_in_q, gate_in_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [N_IN:0]   err_q, err_d;
   logic            fv_q, fv_d;
   logic [N_IN-1:0] fvec_q, fvec_d;

   logic            mism;
   logic [N_IN:0]   err_nxt;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wcnt_d    = wcnt_q;
      gate_in_d = gate_in_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      err_d     = err_q;
      fv_d      = fv_q;
      fvec_d    = fvec_q;
      mism      = gate_out_i != EXPECT[idx_q];
      err_nxt   = err_q + {{N_IN{1'b0}}, mism};

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               idx_d     = '0;
               gate_in_d = '0;
               err_d     = '0;
               fv_d      = 1'b0;
               fvec_d    = '0;
               pass_d    = 1'b0;
               busy_d    = 1'b1;
               wcnt_d    = WLOAD;
               state_d   = S_AFTER_VEC;
            end
         end
         S_SETTLE: begin
            if (abort_i) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               gate_in_d = '0;
               pass_d    = 1'b0;
            end else if (wcnt_q == 4'd0) begin
               state_d = S_SAMPLE;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         S_SAMPLE: begin
            if (abort_i) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               gate_in_d = '0;
               pass_d    = 1'b0;
            end else begin
               err_d = err_nxt;
               if (mism && !fv_q) begin
                  fv_d   = 1'b1;
                  fvec_d = idx_q;
               end
               // Last vector: verdict includes this cycle's mismatch.
               if (&idx_q) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_nxt == '0);
               end else begin
                  idx_d     = idx_q + 1'b1;
                  gate_in_d = idx_q + 1'b1;
                  wcnt_d    = WLOAD;
                  state_d   = S_AFTER_VEC;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         wcnt_q    <= '0;
         gate_in_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= '0;
         fv_q      <= 1'b0;
         fvec_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wcnt_q    <= wcnt_d;
         gate_in_q <= gate_in_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
         fv_q      <= fv_d;
         fvec_q    <= fvec_d;
      end
   end

   assign gate_in_o    = gate_in_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign err_count_o  = err_q;
   assign fail_valid_o = fv_q;
   assign fail_vec_o   = fvec_q;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Scoreboard bench for gate_truth_table_sequencer: stimulus queues expected run
// results, a monitor checks them on each done pulse; directed checks for abort/reset.
module tb_gate_truth_table_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, start0 = 1'b0;
   logic       gate_out, gate_out0;
   logic [1:0] gate_in, gate_in0;
   logic       busy, done, pass, fv;
   logic       busy0, done0, pass0, fv0;
   logic [2:0] errc, errc0;
   logic [1:0] fvec, fvec0;
   int         mode = 0;   // 0 nand, 1 and, 2 stuck-at-1
   int         cyc = 0;
   int         n_chk = 0, n_fail = 0, done_cnt = 0;

   typedef struct {
      int cyc; int err; int fv; int fvec; int pass;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign gate_out  = (mode == 0) ? ~&gate_in : (mode == 1) ? &gate_in : 1'b1;
   assign gate_out0 = ~&gate_in0;

   gate_truth_table_sequencer #(.N_IN(2), .SETTLE(1), .EXPECT(4'b0111)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
      .gate_out_i(gate_out), .gate_in_o(gate_in), .busy_o(busy), .done_o(done),
      .pass_o(pass), .err_count_o(errc), .fail_valid_o(fv), .fail_vec_o(fvec));

   gate_truth_table_sequencer #(.N_IN(2), .SETTLE(0), .EXPECT(4'b0111)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .abort_i(1'b0),
      .gate_out_i(gate_out0), .gate_in_o(gate_in0), .busy_o(busy0), .done_o(done0),
      .pass_o(pass0), .err_count_o(errc0), .fail_valid_o(fv0), .fail_vec_o(fvec0));

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("err_count", int'(errc), e.err);
            chk("fail_valid", int'(fv), e.fv);
            chk("fail_vec", int'(fvec), e.fvec);
            chk("pass", int'(pass), e.pass);
            chk("busy_in_done", int'(busy), 0);
         end
         done_cnt++;
      end
   end

   task automatic run(input int m, input int err, input int fvl, input int fvc,
                      input int ps, output int c0);
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c0 = cyc;
      q.push_back('{c0 + 8, err, fvl, fvc, ps});
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 60 && done_cnt < target; i++) @(negedge clk);
      if (done_cnt < target) chk("done_timeout", done_cnt, target);
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gate_in"}, int'(gate_in), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_err"}, int'(errc), 0);
      chk({tag, "_fv"}, int'(fv), 0);
      chk({tag, "_fvec"}, int'(fvec), 0);
   endtask

   initial begin
      int c0, t;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // Test 1: nand model, vector walk 00,01,10,11 at 2 cycles each
      run(0, 0, 0, 0, 1, c0);
      for (int k = 0; k < 8; k++) begin
         chk("walk_gate_in", int'(gate_in), k / 2);
         chk("walk_busy", int'(busy), 1);
         @(negedge clk);
      end
      wait_done(1);
      chk("done_one_cycle", int'(done), 0);
      repeat (3) @(negedge clk);
      chk("pass_held", int'(pass), 1);
      chk("gate_in_held", int'(gate_in), 3);

      // Test 2: and model mismatches everywhere
      run(1, 4, 1, 0, 0, c0);
      wait_done(2);

      // Test 3: stuck-at-1 fails only on vector 11, then clean rerun
      run(2, 1, 1, 3, 0, c0);
      wait_done(3);
      run(0, 0, 0, 0, 1, c0);
      chk("rerun_err_cleared", int'(errc), 0);
      chk("rerun_pass_cleared", int'(pass), 0);
      wait_done(4);

      // Test 4: start held high -> back-to-back runs, second accepted after DONE
      @(negedge clk);
      mode  = 0;
      start = 1'b1;
      @(negedge clk);
      c0 = cyc;
      q.push_back('{c0 + 8, 0, 0, 0, 1});
      q.push_back('{c0 + 18, 0, 0, 0, 1});
      repeat (11) @(negedge clk);
      start = 1'b0;
      wait_done(6);
      repeat (4) @(negedge clk);

      // Test 4b: SETTLE=0 instance finishes 4 edges after start
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      c0 = cyc;
      t = -1;
      for (int i = 0; i < 20 && t < 0; i++) begin
         if (done0) t = cyc - c0;
         else @(negedge clk);
      end
      chk("settle0_latency", t, 4);
      chk("settle0_pass", int'(pass0), 1);

      // Test 5: abort while gate_in=10 with and model (2 mismatches so far)
      run(1, 0, 0, 0, 0, c0);
      void'(q.pop_back());
      repeat (4) @(negedge clk);
      chk("pre_abort_gate_in", int'(gate_in), 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_gate_in", int'(gate_in), 0);
      chk("abort_pass", int'(pass), 0);
      chk("abort_err_partial", int'(errc), 2);
      chk("abort_fv", int'(fv), 1);
      chk("abort_fvec", int'(fvec), 0);
      repeat (12) @(negedge clk);
      chk("abort_no_done", done_cnt, 6);

      // Test 6: reset during SAMPLE of vector 01, then a normal run
      run(1, 0, 0, 0, 0, c0);
      void'(q.pop_back());
      repeat (3) @(negedge clk);
      chk("pre_reset_gate_in", int'(gate_in), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_vals("midrun_reset");
      repeat (12) @(negedge clk);
      chk("reset_no_done", done_cnt, 6);
      run(0, 0, 0, 0, 1, c0);
      wait_done(7);

      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
